// File: rtl/sram_mem_responder_if.sv
// rtl/sram_mem_responder_if.sv - MEM-stage request/response bus between EX_MEM register and SRAM responder
interface sram_mem_responder_if;
  logic        MEM_R_EN;
  logic        MEM_W_EN;
  logic [31:0] address;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;

  modport master (
    output MEM_R_EN, MEM_W_EN, address, wdata,
    input  rdata, ready
  );

  modport slave (
    input  MEM_R_EN, MEM_W_EN, address, wdata,
    output rdata, ready
  );
endinterface

// File: rtl/sram_mem_responder.sv
// rtl/sram_mem_responder.sv - word load/store responder performing two 16-bit SRAM accesses per request
module sram_mem_responder #(
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_CYCLES = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  sram_mem_responder_if.slave      bus,
  output logic [17:0]              sram_addr,
  inout  wire  [15:0]              sram_dq,
  output logic                     sram_we_n
);

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t        state, state_next;
  logic [CW-1:0] count;
  logic          op_write;
  logic [16:0]   word_q;
  logic          half_q;
  logic [31:0]   wdata_q;
  logic [15:0]   lo_q;
  logic [31:0]   rdata_q;
  logic          ready;
  logic          drive;
  logic [15:0]   dq_out;
  logic          req;
  logic          last;
  logic [16:0]   word_in;

  assign req     = bus.MEM_R_EN | bus.MEM_W_EN;
  assign last    = (count == CW'(WAIT_CYCLES - 1));
  assign word_in = 17'((bus.address - 32'(BASE_ADDR)) >> 2);

  always_comb begin
    state_next = state;
    ready      = 1'b0;
    drive      = 1'b0;
    sram_we_n  = 1'b1;
    dq_out     = 16'h0000;
    case (state)
      IDLE: begin
        ready = ~req;
        if (req) state_next = LO;
      end
      LO: begin
        if (op_write) begin
          drive     = 1'b1;
          sram_we_n = 1'b0;
          dq_out    = wdata_q[15:0];
        end
        if (last) state_next = HI;
      end
      HI: begin
        if (op_write) begin
          drive     = 1'b1;
          sram_we_n = 1'b0;
          dq_out    = wdata_q[31:16];
        end
        if (last) state_next = DONE;
      end
      DONE: begin
        ready      = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Low half is staged so rdata only changes when the whole word is in.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      count    <= '0;
      op_write <= 1'b0;
      word_q   <= '0;
      half_q   <= 1'b0;
      wdata_q  <= '0;
      lo_q     <= '0;
      rdata_q  <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (req) begin
            op_write <= bus.MEM_W_EN;
            word_q   <= word_in;
            wdata_q  <= bus.wdata;
            half_q   <= 1'b0;
            count    <= '0;
          end
        end
        LO: begin
          if (last) begin
            count  <= '0;
            half_q <= 1'b1;
            if (!op_write) lo_q <= sram_dq;
          end else begin
            count <= count + CW'(1);
          end
        end
        HI: begin
          if (last) begin
            count <= '0;
            if (!op_write) rdata_q <= {sram_dq, lo_q};
          end else begin
            count <= count + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign sram_addr = {word_q, half_q};
  assign sram_dq   = drive ? dq_out : 16'bz;
  assign bus.ready = ready;
  assign bus.rdata = rdata_q;

endmodule
